// File: rtl/arpeggiator_n.sv
// N-key arpeggiator: plays held keys one at a time in up/down/up-down order, or bypasses key_on.
// Outputs are combinational from state registers and live key_on; steps last countermax+1 cycles.
module arpeggiator_n #(
    parameter int NUM_KEYS = 8,
    parameter int CNT_W    = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        Enable,
    input  logic [NUM_KEYS-1:0]         key_on,
    input  logic [CNT_W-1:0]            countermax,
    input  logic [CNT_W-1:0]            gate_len,
    input  logic [1:0]                  mode,
    output logic [NUM_KEYS-1:0]         note_on,
    output logic [$clog2(NUM_KEYS)-1:0] cur_key,
    output logic                        step_pulse
);
    localparam int IDX_W = $clog2(NUM_KEYS);

    typedef enum logic [1:0] {ST_RST, ST_BYPASS, ST_IDLE, ST_PLAY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic               dir_q, dir_d;

    logic [IDX_W-1:0]   lo_idx, hi_idx, up_idx, dn_idx, nxt_idx, entry_idx;
    logic               up_fnd, dn_fnd, nxt_dir, any_key, step_end;
    logic [NUM_KEYS-1:0] cur_oh;

    // Priority search over held keys relative to the current key.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        up_idx = '0;
        dn_idx = '0;
        up_fnd = 1'b0;
        dn_fnd = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_on[i]) begin
                lo_idx = IDX_W'(i);
                if (i > int'(cur_q)) begin
                    up_idx = IDX_W'(i);
                    up_fnd = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_on[i]) begin
                hi_idx = IDX_W'(i);
                if (i < int'(cur_q)) begin
                    dn_idx = IDX_W'(i);
                    dn_fnd = 1'b1;
                end
            end
        end
    end

    always_comb begin
        nxt_idx = up_fnd ? up_idx : lo_idx;
        nxt_dir = 1'b0;
        case (mode)
            2'b01: nxt_idx = dn_fnd ? dn_idx : hi_idx;
            2'b10: begin
                // Bounce at the ends: flip direction rather than replay the endpoint.
                nxt_idx = cur_q;
                nxt_dir = dir_q;
                if (!dir_q) begin
                    if (up_fnd)      begin nxt_idx = up_idx; nxt_dir = 1'b0; end
                    else if (dn_fnd) begin nxt_idx = dn_idx; nxt_dir = 1'b1; end
                end else begin
                    if (dn_fnd)      begin nxt_idx = dn_idx; nxt_dir = 1'b1; end
                    else if (up_fnd) begin nxt_idx = up_idx; nxt_dir = 1'b0; end
                end
            end
            default: ;
        endcase
    end

    assign entry_idx = (mode == 2'b01) ? hi_idx : lo_idx;
    assign any_key   = |key_on;
    assign cur_oh    = {{(NUM_KEYS-1){1'b0}}, 1'b1} << cur_q;
    assign step_end  = (counter_q >= countermax) || !key_on[cur_q];

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        counter_d  = counter_q;
        dir_d      = dir_q;
        note_on    = '0;
        cur_key    = cur_q;
        step_pulse = 1'b0;
        case (state_q)
            ST_RST: begin
                cur_key = '0;
                state_d = ST_BYPASS;
            end
            ST_BYPASS: begin
                note_on = key_on;
                if (Enable) begin
                    if (any_key) begin
                        state_d   = ST_PLAY;
                        cur_d     = entry_idx;
                        counter_d = '0;
                        dir_d     = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (any_key) begin
                    state_d   = ST_PLAY;
                    cur_d     = entry_idx;
                    counter_d = '0;
                    dir_d     = 1'b0;
                end
            end
            default: begin
                if (counter_q <= gate_len) note_on = cur_oh & key_on;
                step_pulse = (counter_q == '0);
                if (!any_key) begin
                    state_d   = ST_IDLE;
                    counter_d = '0;
                end else if (step_end) begin
                    cur_d     = nxt_idx;
                    dir_d     = nxt_dir;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
        endcase
        if (state_q != ST_RST && !Enable) begin
            state_d   = ST_BYPASS;
            cur_d     = cur_q;
            dir_d     = dir_q;
            counter_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_RST;
            cur_q     <= '0;
            counter_q <= '0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            counter_q <= counter_d;
            dir_q     <= dir_d;
        end
    end
endmodule

// File: tb/tb_arpeggiator_n.sv
// Bench for arpeggiator_n: per-cycle vector table fed through an expected-value queue,
// then a hand-written IDLE -> PLAY sequence with bounded waits on step_pulse.
module tb_arpeggiator_n;
    logic        CLK;
    logic        RESET;
    logic        Enable;
    logic [7:0]  key_on;
    logic [15:0] countermax;
    logic [15:0] gate_len;
    logic [1:0]  mode;
    logic [7:0]  note_on;
    logic [2:0]  cur_key;
    logic        step_pulse;

    int checks = 0;
    int errors = 0;

    arpeggiator_n #(.NUM_KEYS(8), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .Enable(Enable), .key_on(key_on),
        .countermax(countermax), .gate_len(gate_len), .mode(mode),
        .note_on(note_on), .cur_key(cur_key), .step_pulse(step_pulse)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  keys;
        logic [15:0] cmax;
        logic [15:0] gate;
        logic [1:0]  md;
        logic [7:0]  exp_note;
        logic [2:0]  exp_cur;
        logic        exp_sp;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic r, input logic e, input logic [7:0] k,
                                input int cm, input int gl, input logic [1:0] m,
                                input logic [7:0] n, input int c, input logic s);
        vec_t v;
        v.rst = r; v.en = e; v.keys = k; v.cmax = 16'(cm); v.gate = 16'(gl); v.md = m;
        v.exp_note = n; v.exp_cur = 3'(c); v.exp_sp = s;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        vec_t v, e;
        int   gap;
        bit   seen;

        // reset / bypass
        vecs.push_back(mk(1,0,8'h05,0,0,0, 8'h00,0,0));
        vecs.push_back(mk(1,0,8'h05,0,0,0, 8'h00,0,0));
        vecs.push_back(mk(0,0,8'h05,0,0,0, 8'h00,0,0));
        vecs.push_back(mk(0,0,8'h05,0,0,0, 8'h05,0,0));
        vecs.push_back(mk(0,0,8'h05,0,0,0, 8'h05,0,0));
        vecs.push_back(mk(0,0,8'hA3,0,0,0, 8'hA3,0,0));
        // up mode, keys {1,4,6}, 4-cycle steps
        vecs.push_back(mk(0,1,8'h52,3,3,0, 8'h52,0,0));
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                case (r)
                    0, 3: vecs.push_back(mk(0,1,8'h52,3,3,0, 8'h02,1,(c == 0)));
                    1:    vecs.push_back(mk(0,1,8'h52,3,3,0, 8'h10,4,(c == 0)));
                    default: vecs.push_back(mk(0,1,8'h52,3,3,0, 8'h40,6,(c == 0)));
                endcase
            end
        end
        vecs.push_back(mk(0,1,8'h52,3,3,0, 8'h10,4,1));
        vecs.push_back(mk(0,1,8'h52,3,3,0, 8'h10,4,0));
        // release key 4 mid-step
        vecs.push_back(mk(0,1,8'h42,3,3,0, 8'h00,4,0));
        vecs.push_back(mk(0,1,8'h42,3,3,0, 8'h40,6,1));
        vecs.push_back(mk(0,1,8'h42,3,3,0, 8'h40,6,0));
        vecs.push_back(mk(0,0,8'h42,3,3,0, 8'h40,6,0));
        // down mode, gate 1, keys {3,7}
        vecs.push_back(mk(0,1,8'h88,3,1,1, 8'h88,6,0));
        vecs.push_back(mk(0,1,8'h88,3,1,1, 8'h80,7,1));
        vecs.push_back(mk(0,1,8'h88,3,1,1, 8'h80,7,0));
        vecs.push_back(mk(0,1,8'h88,3,1,1, 8'h00,7,0));
        vecs.push_back(mk(0,1,8'h88,3,1,1, 8'h00,7,0));
        vecs.push_back(mk(0,1,8'h88,3,1,1, 8'h08,3,1));
        vecs.push_back(mk(0,1,8'h88,3,1,1, 8'h08,3,0));
        vecs.push_back(mk(0,1,8'h88,3,1,1, 8'h00,3,0));
        vecs.push_back(mk(0,1,8'h88,3,1,1, 8'h00,3,0));
        vecs.push_back(mk(0,1,8'h88,3,1,1, 8'h80,7,1));
        vecs.push_back(mk(0,0,8'h88,3,1,1, 8'h80,7,0));
        // up-down, keys {0,2,5}, 2-cycle steps: 0,2,5,2,0,2,5
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h25,7,0));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h01,0,1));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h01,0,0));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h04,2,1));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h04,2,0));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h20,5,1));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h20,5,0));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h04,2,1));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h04,2,0));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h01,0,1));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h01,0,0));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h04,2,1));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h04,2,0));
        vecs.push_back(mk(0,1,8'h25,1,1,2, 8'h20,5,1));
        // countermax drops to 0 mid-step: immediate advance, then a step per cycle
        vecs.push_back(mk(0,1,8'h25,0,0,2, 8'h00,5,0));
        vecs.push_back(mk(0,1,8'h25,0,0,2, 8'h04,2,1));
        vecs.push_back(mk(0,1,8'h25,0,0,2, 8'h01,0,1));
        vecs.push_back(mk(0,1,8'h25,0,0,2, 8'h04,2,1));
        // release all -> IDLE, press key 2 -> PLAY, disable mid-step
        vecs.push_back(mk(0,1,8'h00,0,0,2, 8'h00,5,1));
        vecs.push_back(mk(0,1,8'h00,3,3,0, 8'h00,5,0));
        vecs.push_back(mk(0,1,8'h04,3,3,0, 8'h00,5,0));
        vecs.push_back(mk(0,1,8'h04,3,3,0, 8'h04,2,1));
        vecs.push_back(mk(0,1,8'h14,3,3,0, 8'h04,2,0));
        vecs.push_back(mk(0,1,8'h14,1,3,0, 8'h04,2,0));
        vecs.push_back(mk(0,0,8'h14,1,3,0, 8'h10,4,1));
        vecs.push_back(mk(0,0,8'h14,3,3,0, 8'h14,4,0));
        vecs.push_back(mk(1,0,8'h14,3,3,0, 8'h14,4,0));
        vecs.push_back(mk(1,0,8'h14,3,3,0, 8'h00,0,0));

        RESET = 1'b1; Enable = 1'b0; key_on = 8'h05;
        countermax = '0; gate_len = '0; mode = 2'b00;
        @(posedge CLK); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            RESET = v.rst; Enable = v.en; key_on = v.keys;
            countermax = v.cmax; gate_len = v.gate; mode = v.md;
            exp_q.push_back(v);
            @(negedge CLK);
            e = exp_q.pop_front();
            chk("note_on", i, 32'(note_on), 32'(e.exp_note));
            chk("cur_key", i, 32'(cur_key), 32'(e.exp_cur));
            chk("step_pulse", i, 32'(step_pulse), 32'(e.exp_sp));
            @(posedge CLK); #1;
        end

        // Enable with no keys -> IDLE; first press starts PLAY; 3-cycle step spacing.
        RESET = 1'b0; Enable = 1'b1; key_on = 8'h00;
        countermax = 16'd2; gate_len = 16'd2; mode = 2'b00;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        chk("idle_note", 100, 32'(note_on), 32'h0);
        chk("idle_pulse", 100, 32'(step_pulse), 32'h0);
        key_on = 8'h08;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(posedge CLK); #1;
            if (step_pulse) seen = 1'b1;
        end
        chk("press_pulse_seen", 101, 32'(seen), 32'h1);
        chk("press_cur", 101, 32'(cur_key), 32'h3);
        chk("press_note", 101, 32'(note_on), 32'h08);
        gap = 0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge CLK); #1;
            gap++;
            if (step_pulse) seen = 1'b1;
        end
        chk("step_gap_seen", 102, 32'(seen), 32'h1);
        chk("step_gap", 102, 32'(gap), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
